// File: rtl/mux_bist_pkg.sv
// Shared types and constants for the 2:1 mux self-test sequencer.
// Wire indices follow the order of the observed mux nets, from the inputs to the output.
package mux_bist_pkg;

  localparam int unsigned NUM_WIRES = 9;
  localparam int unsigned NUM_VECS  = 8;

  localparam int unsigned W_I0   = 0;
  localparam int unsigned W_I1   = 1;
  localparam int unsigned W_S0   = 2;
  localparam int unsigned W_S1   = 3;
  localparam int unsigned W_S2   = 4;
  localparam int unsigned W_SN   = 5;
  localparam int unsigned W_AND1 = 6;
  localparam int unsigned W_AND0 = 7;
  localparam int unsigned W_OUT  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StCompare,
    StDone
  } state_e;

endpackage

// File: rtl/mux_golden_model.sv
// Fault-free reference for the nine observable wires of the 2:1 mux.
// Purely combinational; the inputs are the sequencer's registered drives.
module mux_golden_model
  import mux_bist_pkg::*;
(
  input  logic                 s,
  input  logic                 i0,
  input  logic                 i1,
  output logic [NUM_WIRES-1:0] golden
);

  always_comb begin
    golden         = '0;
    golden[W_I0]   = i0;
    golden[W_I1]   = i1;
    // S fans out to three separately observed branches.
    golden[W_S0]   = s;
    golden[W_S1]   = s;
    golden[W_S2]   = s;
    golden[W_SN]   = ~s;
    golden[W_AND1] = i1 & s;
    golden[W_AND0] = i0 & ~s;
    golden[W_OUT]  = (i1 & s) | (i0 & ~s);
  end

endmodule

// File: rtl/mux_fault_sequencer.sv
// Walks the 2:1 mux through all eight input vectors and reports the first stuck-at wire.
// Define FAULT_SWEEP_EN to run all vectors and also report a sticky fault_mask.
module mux_fault_sequencer
  import mux_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] obs,
  output logic       s_o,
  output logic       i0_o,
  output logic       i1_o,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] fault_idx,
  output logic       stuck_val,
  output logic [2:0] vec_idx
`ifdef FAULT_SWEEP_EN
  ,
  output logic [8:0] fault_mask
`endif
);

  state_e state_q, state_d;

  logic [2:0] v_q;
  logic [3:0] cnt_q;
  logic       fault_q;
  logic [3:0] idx_q;
  logic       stuck_q;
  logic [2:0] fail_vec_q;

  logic [NUM_WIRES-1:0] golden;
  logic [NUM_WIRES-1:0] diff;
  logic [3:0]           enc;
  logic                 any_diff;
  logic                 last_vec;
  logic                 settle_done;
  logic                 accept;
  logic                 advance;

  assign {i0_o, i1_o, s_o} = v_q;

  mux_golden_model u_golden (
    .s      (s_o),
    .i0     (i0_o),
    .i1     (i1_o),
    .golden (golden)
  );

  assign diff        = obs ^ golden;
  assign any_diff    = |diff;
  assign last_vec    = (v_q == 3'(NUM_VECS - 1));
  assign settle_done = (cnt_q == 4'(SETTLE_CYCLES - 1));
  assign accept      = start && ((state_q == StIdle) || (state_q == StDone));

  // Lowest mismatching index wins.
  always_comb begin
    enc = '0;
    for (int i = int'(NUM_WIRES) - 1; i >= 0; i--) begin
      if (diff[i]) enc = 4'(i);
    end
  end

`ifdef FAULT_SWEEP_EN
  assign advance = !last_vec;
`else
  assign advance = !last_vec && !any_diff;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (start) state_d = StApply;
      StApply:        state_d = StSettle;
      StSettle:       if (settle_done) state_d = StCompare;
      StCompare:      state_d = advance ? StApply : StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      StApply, StSettle, StCompare: busy = 1'b1;
      StDone:                       done = 1'b1;
      default:                      ;
    endcase
  end

  // Vector, settle counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q        <= '0;
      cnt_q      <= '0;
      fault_q    <= 1'b0;
      idx_q      <= '0;
      stuck_q    <= 1'b0;
      fail_vec_q <= '0;
`ifdef FAULT_SWEEP_EN
      fault_mask <= '0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            v_q        <= '0;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
            idx_q      <= '0;
            stuck_q    <= 1'b0;
            fail_vec_q <= '0;
`ifdef FAULT_SWEEP_EN
            fault_mask <= '0;
`endif
          end
        end
        StSettle: cnt_q <= settle_done ? 4'd0 : cnt_q + 4'd1;
        StCompare: begin
          if (any_diff && !fault_q) begin
            fault_q    <= 1'b1;
            idx_q      <= enc;
            stuck_q    <= ~golden[enc];
            fail_vec_q <= v_q;
          end
`ifdef FAULT_SWEEP_EN
          fault_mask <= fault_mask | diff;
`endif
          if (advance) v_q <= v_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign fault     = fault_q;
  assign fault_idx = idx_q;
  assign stuck_val = stuck_q;
  // A sweep keeps stepping past the first fault, so report the vector it was seen on.
  assign vec_idx   = (done && fault_q) ? fail_vec_q : v_q;

endmodule

// File: tb/tb_mux_fault_sequencer.sv
// Directed self-checking bench for mux_fault_sequencer with a stuck-at-injectable mux model.
module tb_mux_fault_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] obs;
  logic       s_o, i0_o, i1_o;
  logic       busy, done, fault, stuck_val;
  logic [3:0] fault_idx;
  logic [2:0] vec_idx;
`ifdef FAULT_SWEEP_EN
  logic [8:0] fault_mask;
`endif

  logic [8:0] sa0, sa1, good;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_fault_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .obs       (obs),
    .s_o       (s_o),
    .i0_o      (i0_o),
    .i1_o      (i1_o),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .fault_idx (fault_idx),
    .stuck_val (stuck_val),
    .vec_idx   (vec_idx)
`ifdef FAULT_SWEEP_EN
    ,
    .fault_mask(fault_mask)
`endif
  );

  // Unit under test: a fault-free mux with stuck-at-0/1 overrides.
  always_comb begin
    good[0] = i0_o;
    good[1] = i1_o;
    good[2] = s_o;
    good[3] = s_o;
    good[4] = s_o;
    good[5] = ~s_o;
    good[6] = i1_o & s_o;
    good[7] = i0_o & ~s_o;
    good[8] = (i1_o & s_o) | (i0_o & ~s_o);
    obs     = (good & ~sa0) | sa1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves time at edge 0 + 1.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_expect(input string tag, input int done_edge, input logic f,
                            input logic [3:0] idx, input logic sv, input logic [2:0] vec);
    wait_edges(done_edge - 1);
    check({tag, "_not_early"}, 16'(done), 16'd0);
    wait_edges(1);
    check({tag, "_done"}, 16'(done), 16'd1);
    check({tag, "_busy"}, 16'(busy), 16'd0);
    check({tag, "_fault"}, 16'(fault), 16'(f));
    check({tag, "_idx"}, 16'(fault_idx), 16'(idx));
    check({tag, "_stuck"}, 16'(stuck_val), 16'(sv));
    check({tag, "_vec"}, 16'(vec_idx), 16'(vec));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sa0   = '0;
    sa1   = '0;
    #12;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_fault", 16'(fault), 16'd0);
    check("rst_vec", 16'(vec_idx), 16'd0);
    check("rst_drive", 16'({i0_o, i1_o, s_o}), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fault-free pass
    pulse_start();
    check("t1_busy", 16'(busy), 16'd1);
    run_expect("t1", 32, 1'b0, 4'd0, 1'b0, 3'd7);

`ifndef FAULT_SWEEP_EN
    // ~S branch stuck at 0 fails on the very first vector
    sa0 = 9'b000100000;
    pulse_start();
    run_expect("t2", 4, 1'b1, 4'd5, 1'b0, 3'd0);

    // Output stuck at 0 first shows at v=3
    sa0 = 9'b100000000;
    pulse_start();
    run_expect("t3", 16, 1'b1, 4'd8, 1'b0, 3'd3);

    // Two stuck-at-1 wires: the lower index is reported
    sa0 = '0;
    sa1 = 9'b010000010;
    pulse_start();
    run_expect("t4", 4, 1'b1, 4'd1, 1'b1, 3'd0);
    sa1 = '0;
`else
    sa0 = 9'b100000100;
    pulse_start();
    run_expect("t6", 32, 1'b1, 4'd2, 1'b0, 3'd1);
    check("t6_mask", 16'(fault_mask), 16'h104);
    sa0 = '0;
`endif

    // Start while busy is ignored; async reset mid-run
    pulse_start();
    wait_edges(8);
    check("t5_vec2", 16'(vec_idx), 16'd2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t5_ign_busy", 16'(busy), 16'd1);
    check("t5_ign_vec", 16'(vec_idx), 16'd2);
    wait_edges(7);
    check("t5_vec4", 16'(vec_idx), 16'd4);
    check("t5_drive4", 16'({i0_o, i1_o, s_o}), 16'd4);
    wait_edges(1);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    #1;
    check("t5_rst_busy", 16'(busy), 16'd0);
    check("t5_rst_vec", 16'(vec_idx), 16'd0);
    check("t5_rst_drive", 16'({i0_o, i1_o, s_o}), 16'd0);
    check("t5_rst_done", 16'(done), 16'd0);
    wait_edges(1);
    check("t5_rst_wins", 16'(busy), 16'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    pulse_start();
    run_expect("t5", 32, 1'b0, 4'd0, 1'b0, 3'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
